// File: rtl/corescore_uart_tx.sv
// Stream-to-UART transmitter: serialises valid/ready/last byte beats as 8N1/8N2 frames,
// optionally following each last-flagged beat with a line-feed frame.
module corescore_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int APPEND_LF    = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tdata,
    input  logic       i_tlast,
    input  logic       i_tvalid,
    output logic       o_tready,
    output logic       o_uart_tx,
    output logic       o_busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nx;
    logic [BW-1:0] baud, baud_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shift, shift_nx;
    logic          lf_pending, lf_nx;
    logic          tx_nx, tready_nx;
    logic          baud_end;

    assign baud_end = (baud == BAUD_LAST);
    assign o_busy   = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            lf_pending <= 1'b0;
            o_uart_tx  <= 1'b1;
            o_tready   <= 1'b0;
        end else begin
            state      <= state_nx;
            baud       <= baud_nx;
            bit_idx    <= bit_idx_nx;
            shift      <= shift_nx;
            lf_pending <= lf_nx;
            o_uart_tx  <= tx_nx;
            o_tready   <= tready_nx;
        end
    end

    // Line level is registered, so each branch sets the value for the *next* cycle.
    always_comb begin
        state_nx   = state;
        baud_nx    = baud_end ? '0 : baud + 1'b1;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        lf_nx      = lf_pending;
        tx_nx      = o_uart_tx;
        tready_nx  = 1'b0;
        case (state)
            IDLE: begin
                tx_nx      = 1'b1;
                tready_nx  = 1'b1;
                baud_nx    = '0;
                bit_idx_nx = '0;
                if (i_tvalid && o_tready) begin
                    shift_nx  = i_tdata;
                    lf_nx     = (APPEND_LF != 0) && i_tlast;
                    tready_nx = 1'b0;
                    tx_nx     = 1'b0;
                    state_nx  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    state_nx   = DATA;
                    tx_nx      = shift[0];
                    bit_idx_nx = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nx   = STOP;
                        tx_nx      = 1'b1;
                        bit_idx_nx = '0;
                    end else begin
                        shift_nx   = shift >> 1;
                        tx_nx      = shift[1];
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (bit_idx == STOP_LAST) begin
                        if (lf_pending) begin
                            shift_nx = 8'h0A;
                            lf_nx    = 1'b0;
                            tx_nx    = 1'b0;
                            state_nx = START;
                        end else begin
                            state_nx  = IDLE;
                            tready_nx = 1'b1;
                        end
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_corescore_uart_tx.sv
// Directed + randomized bench for corescore_uart_tx; expected line waveforms are built
// from the frame format (start, 8 data bits LSB first, stop bits) at CLKS_PER_BIT=4.
module tb_corescore_uart_tx;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_tdata, b_tdata;
    logic       a_tlast, b_tlast, a_tvalid, b_tvalid;
    logic       a_tready, b_tready, a_tx, b_tx, a_busy, b_busy;

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned cyc = 0;
    int unsigned last_xfer = 0;
    logic        exp_q[$];

    always #5 clk = ~clk;

    // dut_a: 1 stop bit, line feed appended; dut_b: 2 stop bits, no line feed
    corescore_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .APPEND_LF(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_tdata(a_tdata), .i_tlast(a_tlast), .i_tvalid(a_tvalid),
        .o_tready(a_tready), .o_uart_tx(a_tx), .o_busy(a_busy));

    corescore_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2), .APPEND_LF(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_tdata(b_tdata), .i_tlast(b_tlast), .i_tvalid(b_tvalid),
        .o_tready(b_tready), .o_uart_tx(b_tx), .o_busy(b_busy));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    function automatic logic get_tx(input int sel);
        return (sel == 0) ? a_tx : b_tx;
    endfunction

    function automatic logic get_tready(input int sel);
        return (sel == 0) ? a_tready : b_tready;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? a_busy : b_busy;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l);
        if (sel == 0) begin
            a_tvalid = v; a_tdata = d; a_tlast = l;
        end else begin
            b_tvalid = v; b_tdata = d; b_tlast = l;
        end
    endtask

    function automatic void add_frame(input logic [7:0] b, input int unsigned stops);
        for (int unsigned c = 0; c < CPB; c++) exp_q.push_back(1'b0);
        for (int unsigned i = 0; i < 8; i++)
            for (int unsigned c = 0; c < CPB; c++) exp_q.push_back(b[i]);
        for (int unsigned c = 0; c < stops * CPB; c++) exp_q.push_back(1'b1);
    endfunction

    task automatic wait_hs(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (get_tready(sel)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    // Offer a byte, then check every line cycle of the resulting frame(s) and the return to idle.
    task automatic send(input int sel, input logic [7:0] b, input logic last,
                        input bit hold, input logic [7:0] next_b);
        bit ok;
        drive(sel, 1'b1, b, last);
        wait_hs(sel, ok);
        if (!ok) return;
        last_xfer = cyc;
        exp_q.delete();
        add_frame(b, (sel == 0) ? 1 : 2);
        if (sel == 0 && last) add_frame(8'h0A, 1);
        step();
        if (hold) drive(sel, 1'b1, next_b, 1'b0);
        else drive(sel, 1'b0, $urandom_range(0, 255), $urandom_range(0, 1));
        foreach (exp_q[k]) begin
            chk("line", get_tx(sel), exp_q[k]);
            chk("tready_in_frame", get_tready(sel), 1'b0);
            chk("busy_in_frame", get_busy(sel), 1'b1);
            step();
        end
        chk("tready_after", get_tready(sel), 1'b1);
        chk("busy_after", get_busy(sel), 1'b0);
        chk("line_idle_after", get_tx(sel), 1'b1);
    endtask

    initial begin
        int unsigned t_first;
        bit ok;
        logic [7:0] rb;
        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (3) step();
        chk("rst_tready_a", a_tready, 1'b0);
        chk("rst_tx_a", a_tx, 1'b1);
        chk("rst_busy_a", a_busy, 1'b0);
        chk("rst_tready_b", b_tready, 1'b0);
        chk("rst_tx_b", b_tx, 1'b1);
        rst = 1'b0;
        step();
        chk("tready_first_cycle", a_tready, 1'b1);
        for (int i = 0; i < 100; i++) begin
            chk("idle_tx", a_tx, 1'b1);
            chk("idle_tready", a_tready, 1'b1);
            step();
        end

        send(0, 8'h55, 1'b0, 1'b0, 8'h00);

        // "Hi" with valid held across frames
        send(0, 8'h48, 1'b0, 1'b1, 8'h69);
        t_first = last_xfer;
        send(0, 8'h69, 1'b0, 1'b0, 8'h00);
        chk("b2b_spacing", last_xfer - t_first, 32'd41);

        send(0, 8'h21, 1'b1, 1'b0, 8'h00);
        send(0, 8'h21, 1'b0, 1'b0, 8'h00);

        send(1, 8'hFF, 1'b0, 1'b0, 8'h00);
        send(1, 8'h3A, 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) step();
            rb = 8'($urandom_range(0, 255));
            send(0, rb, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
        end

        // Reset during data bit 3, then a clean frame
        drive(0, 1'b1, 8'hC3, 1'b1);
        wait_hs(0, ok);
        step();
        drive(0, 1'b0, 8'h00, 1'b0);
        repeat (17) step();
        chk("bit3_before_rst", a_tx, 1'b0);
        chk("busy_before_rst", a_busy, 1'b1);
        rst = 1'b1;
        step();
        chk("midrst_tx", a_tx, 1'b1);
        chk("midrst_busy", a_busy, 1'b0);
        chk("midrst_tready", a_tready, 1'b0);
        rst = 1'b0;
        step();
        chk("midrst_release_tready", a_tready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("post_rst_idle", a_tx, 1'b1);
            step();
        end
        send(0, 8'hA5, 1'b0, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
